riptide_dcache_ctrl: RTL and testbench

// Data-side responder for the RIPTIDE-II core: services the core's data address, write data, write/read

---
 rtl/riptide_dcache_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_riptide_dcache_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riptide_dcache_ctrl.sv
// ---------------------------------------------------------------------------
// riptide_dcache_ctrl
//
// Data-side cache controller for the RIPTIDE-II core. It is direct-mapped,
// write-back and write-allocate. The core is stalled with d_cache_miss while
// a dirty victim line is written back and the new line is filled. Both
// transfers are one word at a time over a req/ack port to the SDRAM arbiter.
//
// Ports
//   clk, n_reset        system clock; asynchronous active-low reset
//   address             core word address, split as tag | index | word
//   data_out            core write data
//   data_in             read data: the full word, and the core picks the lane
//   IO_WC / IO_RC       write / read strobes (either one makes an access)
//   IO_n_LB_w           write lane select (0: [15:8], 1: [7:0])
//   d_cache_miss        stall request to the core (combinational)
//   mem_req, mem_we     word transfer request; 1 = write-back, 0 = fill
//   mem_addr, mem_wdata registered transfer address / write-back data
//   mem_rdata, mem_ack  fill data and transfer completion from SDRAM side
// ---------------------------------------------------------------------------
module riptide_dcache_ctrl #(
  parameter int INDEX_BITS = 6,
  parameter int WORD_BITS  = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] address,
  input  logic [15:0] data_out,
  output logic [15:0] data_in,
  input  logic        IO_WC,
  input  logic        IO_RC,
  input  logic        IO_n_LB_w,
  output logic        d_cache_miss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int LINE_BITS = INDEX_BITS + WORD_BITS;
  localparam int TAG_BITS  = 16 - LINE_BITS;
  localparam int LINES     = 2 ** INDEX_BITS;
  localparam int WORDS     = 2 ** WORD_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_UPDATE
  } state_t;

  // Line state and storage
  logic [LINES-1:0]    r_valid;
  logic [LINES-1:0]    r_dirty;
  logic [TAG_BITS-1:0] r_tag_mem  [LINES];
  logic [15:0]         r_data_mem [LINES*WORDS];

  // Controller state
  state_t               r_state;
  logic [WORD_BITS-1:0] r_cnt;
  logic [INDEX_BITS-1:0] r_miss_index;
  logic [TAG_BITS-1:0]  r_miss_tag;

  // Address fields of the current core access
  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_index;
  logic [WORD_BITS-1:0]  w_word;
  logic [LINE_BITS-1:0]  w_rd_addr;

  logic                 w_access;
  logic                 w_hit;
  logic                 w_idle_hit;
  logic                 w_write_hit;
  logic                 w_fill_we;
  logic                 w_last;
  logic [WORD_BITS-1:0] w_cnt_next;

  assign w_tag      = address[15:LINE_BITS];
  assign w_index    = address[LINE_BITS-1:WORD_BITS];
  assign w_word     = address[WORD_BITS-1:0];
  assign w_rd_addr  = {w_index, w_word};

  assign w_access    = IO_RC | IO_WC;
  assign w_hit       = r_valid[w_index] & (r_tag_mem[w_index] == w_tag);
  assign w_idle_hit  = (r_state == S_IDLE) & w_hit;
  assign w_write_hit = w_idle_hit & IO_WC;
  // mem_req is always high in FILL, so an ack there is always a real one.
  assign w_fill_we   = (r_state == S_FILL) & mem_req & mem_ack;
  assign w_last      = &r_cnt;
  assign w_cnt_next  = r_cnt + 1'b1;

  // The read is asynchronous. A write on this edge only shows up after the
  // edge, so a combined read+write returns the pre-write word.
  assign data_in = r_data_mem[w_rd_addr];

  // Held low during reset even if the core presents an access.
  assign d_cache_miss = n_reset & w_access & ~w_idle_hit;

  // NOTE: the tag and data arrays have no reset. The valid bits alone decide
  // whether their contents mean anything, and with no reset they can map to
  // plain RAM.
  always_ff @(posedge clk) begin
    if (w_write_hit) begin
      if (IO_n_LB_w) r_data_mem[w_rd_addr][7:0]  <= data_out[7:0];
      else           r_data_mem[w_rd_addr][15:8] <= data_out[15:8];
    end
    if (w_fill_we) begin
      r_data_mem[{r_miss_index, r_cnt}] <= mem_rdata;
    end
    if (r_state == S_UPDATE) begin
      r_tag_mem[r_miss_index] <= r_miss_tag;
    end
  end

  // Miss FSM. Its outputs to the SDRAM side are registered and are only
  // changed by a miss in IDLE or by an ack.
  // NOTE: non-blocking assignments make every register take its next value
  // from the values present before this edge, whatever the statement order.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_miss_index <= '0;
      r_miss_tag   <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_write_hit) begin
            r_dirty[w_index] <= 1'b1;
          end
          if (w_access && !w_hit) begin
            // Capture the line being replaced. Once a sequence has started it
            // no longer depends on the core's bus, so a flush can't corrupt it.
            r_miss_index <= w_index;
            r_miss_tag   <= w_tag;
            mem_req      <= 1'b1;
            if (r_valid[w_index] && r_dirty[w_index]) begin
              r_state   <= S_WB;
              mem_we    <= 1'b1;
              mem_addr  <= {r_tag_mem[w_index], w_index, r_cnt};
              mem_wdata <= r_data_mem[{w_index, r_cnt}];
            end else begin
              r_state  <= S_FILL;
              mem_we   <= 1'b0;
              mem_addr <= {w_tag, w_index, r_cnt};
            end
          end
        end

        S_WB: begin
          if (mem_ack) begin
            r_cnt <= w_cnt_next;
            if (w_last) begin
              // Go straight on to the fill. The request stays high.
              r_state  <= S_FILL;
              mem_we   <= 1'b0;
              mem_addr <= {r_miss_tag, r_miss_index, w_cnt_next};
            end else begin
              mem_addr  <= {r_tag_mem[r_miss_index], r_miss_index, w_cnt_next};
              mem_wdata <= r_data_mem[{r_miss_index, w_cnt_next}];
            end
          end
        end

        S_FILL: begin
          if (mem_ack) begin
            r_cnt <= w_cnt_next;
            if (w_last) begin
              r_state <= S_UPDATE;
              mem_req <= 1'b0;
            end else begin
              mem_addr <= {r_miss_tag, r_miss_index, w_cnt_next};
            end
          end
        end

        S_UPDATE: begin
          // The line is now complete. A pending write hits next cycle and
          // sets dirty again.
          r_valid[r_miss_index] <= 1'b1;
          r_dirty[r_miss_index] <= 1'b0;
          r_state               <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riptide_dcache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_riptide_dcache_ctrl
//
// Self-checking bench for riptide_dcache_ctrl. Three processes share a model
// of the cache contents and of external memory:
//   - the access model: per-line valid/dirty/tag/data arrays plus an
//     expected-transfer queue, checked against the core-side outputs on every
//     falling edge
//   - an SDRAM responder: acks after random delays, puts noise acks on the
//     bus while idle, and checks each transfer plus its stability while held
//   - the main stimulus: directed scenarios, then random accesses
// ---------------------------------------------------------------------------
module tb_riptide_dcache_ctrl;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [15:0] address, data_out, data_in;
  logic        IO_WC, IO_RC, IO_n_LB_w;
  logic        d_cache_miss;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  riptide_dcache_ctrl #(.INDEX_BITS(6), .WORD_BITS(2)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .address      (address),
    .data_out     (data_out),
    .data_in      (data_in),
    .IO_WC        (IO_WC),
    .IO_RC        (IO_RC),
    .IO_n_LB_w    (IO_n_LB_w),
    .d_cache_miss (d_cache_miss),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] data;
  } xfer_t;

  logic [15:0] ext_mem [0:65535];
  bit          mvalid  [64];
  bit          mdirty  [64];
  logic [7:0]  mtag    [64];
  logic [15:0] mdata   [256];

  xfer_t exp_q[$];
  xfer_t xfer_log[$];

  bit         busy          = 1'b0;
  bit         first_req_due = 1'b0;
  int         install_cyc   = -1;
  logic [5:0] pend_idx;
  logic [7:0] pend_tag;
  int         served        = 0;

  logic [15:0] stall_addr  = 16'h0;
  bit          stall_armed = 1'b0;
  int          stall_len   = 0;
  int          resp_hold   = 0;
  bit          resp_fresh  = 1'b1;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
    exp_q.delete();
    busy          = 1'b0;
    first_req_due = 1'b0;
    install_cyc   = -1;
  endtask

  // Compare process: core-side outputs against the model on every cycle.
  initial begin
    logic [5:0] idx;
    logic [7:0] tag;
    bit         acc;
    forever begin
      @(negedge clk);
      if (n_reset) begin
        acc = IO_RC | IO_WC;
        // Once the last fill word is taken, one more stall cycle follows and
        // then the new line is usable.
        if (busy && install_cyc >= 0 && cyc >= install_cyc) begin
          for (int w = 0; w < 4; w++)
            mdata[{pend_idx, 2'(w)}] = ext_mem[{pend_tag, pend_idx, 2'(w)}];
          mvalid[pend_idx] = 1'b1;
          mtag[pend_idx]   = pend_tag;
          mdirty[pend_idx] = 1'b0;
          busy        = 1'b0;
          install_cyc = -1;
        end
        if (busy) begin
          check("miss_stall", d_cache_miss, acc);
          if (first_req_due) begin
            check("first_req", mem_req, 1'b1);
            first_req_due = 1'b0;
          end
        end else if (acc) begin
          idx = address[7:2];
          tag = address[15:8];
          if (mvalid[idx] && mtag[idx] == tag) begin
            check("hit_miss", d_cache_miss, 1'b0);
            check("hit_data", data_in, mdata[address[7:0]]);
            check("hit_req", mem_req, 1'b0);
            if (IO_WC) begin
              if (IO_n_LB_w) mdata[address[7:0]][7:0]  = data_out[7:0];
              else           mdata[address[7:0]][15:8] = data_out[15:8];
              mdirty[idx] = 1'b1;
            end
            served++;
          end else begin
            check("miss_detect", d_cache_miss, 1'b1);
            check("miss_req_idle", mem_req, 1'b0);
            if (mvalid[idx] && mdirty[idx])
              for (int w = 0; w < 4; w++)
                exp_q.push_back('{1'b1, {mtag[idx], idx, 2'(w)}, mdata[{idx, 2'(w)}]});
            for (int w = 0; w < 4; w++)
              exp_q.push_back('{1'b0, {tag, idx, 2'(w)}, 16'h0});
            pend_idx      = idx;
            pend_tag      = tag;
            busy          = 1'b1;
            first_req_due = 1'b1;
          end
        end else begin
          check("idle_miss", d_cache_miss, 1'b0);
          check("idle_req", mem_req, 1'b0);
        end
      end
    end
  end

  // SDRAM responder: random ack latency, noise acks while mem_req is low.
  initial begin
    xfer_t cap;
    xfer_t e;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!n_reset) begin
        resp_fresh = 1'b1;
        resp_hold  = 0;
      end else if (mem_req) begin
        if (resp_fresh) begin
          resp_fresh = 1'b0;
          cap = '{mem_we, mem_addr, mem_wdata};
          xfer_log.push_back(cap);
          check("xfer_pending", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q[0];
            check("xfer_we", mem_we, e.we);
            check("xfer_addr", mem_addr, e.addr);
            if (e.we) check("xfer_wdata", mem_wdata, e.data);
          end
          if (stall_armed && mem_addr == stall_addr) begin
            resp_hold   = stall_len;
            stall_armed = 1'b0;
          end else begin
            resp_hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
          end
        end else begin
          check("hold_addr", mem_addr, cap.addr);
          check("hold_we_wdata", {mem_we, mem_wdata}, {cap.we, cap.data});
        end
        if (resp_hold > 0) begin
          resp_hold--;
        end else begin
          mem_ack = 1'b1;
          if (mem_we) ext_mem[mem_addr] = mem_wdata;
          else        mem_rdata = ext_mem[mem_addr];
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          if (exp_q.size() == 0) install_cyc = cyc + 2;
          resp_fresh = 1'b1;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        // This ack arrives with mem_req low and must be ignored.
        mem_ack   = 1'b1;
        mem_rdata = 16'($urandom);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_access(input logic [15:0] a, input bit rd, input bit wr, input bit lb,
                           input logic [15:0] wd, input int flush_after);
    int s0;
    int n;
    bit flushed;
    s0 = served;
    n = 0;
    flushed = 1'b0;
    address = a; data_out = wd; IO_n_LB_w = lb; IO_RC = rd; IO_WC = wr;
    while (served == s0 && n < 400) begin
      @(posedge clk); #1; n++;
      if (served == s0 && flush_after > 0 && n == flush_after) begin
        flushed = 1'b1;
        IO_RC = 1'b0; IO_WC = 1'b0;
        while (busy && n < 400) begin
          @(posedge clk); #1; n++;
        end
        break;
      end
    end
    if (flushed) check("flush_complete", busy, 1'b0);
    else         check("access_served", served - s0, 1);
    IO_RC = 1'b0; IO_WC = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected finish before t=400000");
    $fatal(1);
  end

  initial begin
    logic [15:0] wb_exp [4];
    logic [7:0]  tags [4];
    logic [15:0] a;
    logic [15:0] pre;
    int          op;
    bit          found;

    tags = '{8'h00, 8'h10, 8'h20, 8'h30};
    for (int i = 0; i < 65536; i++) ext_mem[i] = 16'($urandom);
    for (int w = 0; w < 4; w++) begin
      ext_mem[16'h0040 + w] = 16'hA000 + 16'(w);
      ext_mem[16'h1040 + w] = 16'hB000 + 16'(w);
    end
    model_reset();

    // Reset state, with a read strobe already present.
    n_reset = 1'b0;
    IO_RC = 1'b1; IO_WC = 1'b0; IO_n_LB_w = 1'b0;
    address = 16'h0040; data_out = 16'h0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_miss", d_cache_miss, 1'b0);
    check("rst_req", mem_req, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 16'h0);
    check("rst_wdata", mem_wdata, 16'h0);
    IO_RC = 1'b0;
    #1 n_reset = 1'b1;
    @(posedge clk); #1;

    // Cold read: four fills at 0x0040..0x0043.
    xfer_log.delete();
    do_access(16'h0040, 1, 0, 0, 16'h0, 0);
    check("cold_data", data_in, 16'hA000);
    check("cold_nxfer", xfer_log.size(), 4);
    for (int i = 0; i < 4 && i < xfer_log.size(); i++)
      check("cold_fill", {xfer_log[i].we, xfer_log[i].addr}, {1'b0, 16'h0040 + 16'(i)});

    // Read hit with no memory traffic.
    xfer_log.delete();
    do_access(16'h0041, 1, 0, 0, 16'h0, 0);
    check("hit_word1", data_in, 16'hA001);
    check("hit_nxfer", xfer_log.size(), 0);

    // Byte-lane writes: the upper lane 0x12 goes over 0xA001, then the lower lane 0x56.
    do_access(16'h0041, 0, 1, 0, 16'h12FF, 0);
    do_access(16'h0041, 1, 0, 0, 16'h0, 0);
    check("wr_hi_lane", data_in, 16'h1201);
    do_access(16'h0041, 0, 1, 1, 16'h3456, 0);
    do_access(16'h0041, 1, 0, 0, 16'h0, 0);
    check("wr_lo_lane", data_in, 16'h1256);

    // Conflict miss on a dirty line: write back, then fill.
    xfer_log.delete();
    wb_exp = '{16'hA000, 16'h1256, 16'hA002, 16'hA003};
    do_access(16'h1041, 1, 0, 0, 16'h0, 0);
    check("conf_nxfer", xfer_log.size(), 8);
    for (int i = 0; i < 4 && i + 4 < xfer_log.size(); i++) begin
      check("conf_wb", {xfer_log[i].we, xfer_log[i].addr, xfer_log[i].data},
            {1'b1, 16'h0040 + 16'(i), wb_exp[i]});
      check("conf_fill", {xfer_log[i+4].we, xfer_log[i+4].addr}, {1'b0, 16'h1040 + 16'(i)});
    end
    check("conf_data", data_in, 16'hB001);

    // Ack held off for 5 cycles on fill word 2.
    stall_addr = 16'h2042; stall_len = 5; stall_armed = 1'b1;
    do_access(16'h2041, 1, 0, 0, 16'h0, 0);
    check("stall_seen", stall_armed, 1'b0);

    // Read and write together: the hit returns the pre-write word, which the
    // compare process checks, then the write lands.
    pre = ext_mem[16'h2043];
    do_access(16'h2043, 1, 1, 0, 16'hCC00, 0);
    check("rdwr_result", data_in, {8'hCC, pre[7:0]});

    // Reset during write-back word 2.
    stall_addr = 16'h2042; stall_len = 1000; stall_armed = 1'b1;
    address = 16'h0041; IO_RC = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (mem_req && mem_we && mem_addr == 16'h2042) found = 1'b1;
    end
    check("rst_wb_reached", found, 1'b1);
    #2 n_reset = 1'b0;
    #1;
    check("rst_mid_req", mem_req, 1'b0);
    check("rst_mid_miss", d_cache_miss, 1'b0);
    model_reset();
    IO_RC = 1'b0; stall_armed = 1'b0;
    @(posedge clk); #3 n_reset = 1'b1;
    @(posedge clk); #1;
    xfer_log.delete();
    do_access(16'h0040, 1, 0, 0, 16'h0, 0);
    check("post_rst_nxfer", xfer_log.size(), 4);
    if (xfer_log.size() > 0)
      check("post_rst_fill", {xfer_log[0].we, xfer_log[0].addr}, {1'b0, 16'h0040});
    check("post_rst_data", data_in, 16'hA000);

    // Random traffic over a few conflicting tags, with occasional flushes.
    for (int n = 0; n < 300; n++) begin
      a  = {tags[$urandom_range(0, 3)], 6'($urandom_range(14, 17)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 2);
      do_access(a, op != 1, op != 0, 1'($urandom_range(0, 1)), 16'($urandom),
                ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
